// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: push/pop request side of the RAM-backed FIFO controller.
//
// Handshake semantics (all signals sampled on the rising clock edge):
//   A push is taken on an edge where wr_ack=1, and a pop is taken on an edge
//   where rd_ack=1. Both acks are combinational and can only be high while
//   ready=1. A requester keeps wr_en/rd_en asserted until it sees the ack.
//   wr_data must be valid while wr_en is high. rd_data is valid in the cycle
//   where rd_valid=1; rd_valid is a single-cycle pulse.
//
// Signals:
//   wr_en, wr_data, rd_en           requester -> controller
//   ready, wr_ack, rd_ack           controller -> requester (handshake)
//   rd_data, rd_valid               controller -> requester (popped word)
//   full, empty, count              controller -> requester (fill status)
interface ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  ready;
  logic                  wr_ack;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;

  // Controller side
  modport slave (
    input  wr_en, wr_data, rd_en,
    output ready, wr_ack, rd_ack, rd_data, rd_valid, full, empty, count
  );

  // Requester side
  modport master (
    output wr_en, wr_data, rd_en,
    input  ready, wr_ack, rd_ack, rd_data, rd_valid, full, empty, count
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller that stores its words in an external
// asynchronous RAM. Every accepted push or pop becomes a one-cycle RAM bus
// operation (WR or RD state), so the controller handles one operation every
// two cycles. Pops take priority over pushes when both are requested.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   f          request/response interface (slave modport)
//   ram_cs     RAM chip select, registered
//   ram_we     RAM write enable, registered
//   ram_addr   RAM address, registered, stable during the cs-active cycle
//   ram_data   bidirectional RAM data; driven only in WR, high-Z otherwise
//   dbg_state  current FSM state (0=IDLE, 1=WR, 2=RD)
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_fifo_ctrl_if.slave        f,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,    count_d;
  logic [DATA_WIDTH-1:0] wr_buf_q,   wr_buf_d;
  logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ram_cs_q,   ram_cs_d;
  logic                  ram_we_q,   ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;

  logic full_w;
  logic empty_w;
  logic wr_ack_w;
  logic rd_ack_w;

  // Flags come from the registered count, never from the pending update.
  assign full_w  = (count_q == FULL_COUNT);
  assign empty_w = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_buf_d   = wr_buf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    wr_ack_w   = 1'b0;
    rd_ack_w   = 1'b0;

    case (state_q)
      IDLE: begin
        // Pop first: a held push is retried on the next idle cycle.
        if (f.rd_en && !empty_w) begin
          rd_ack_w   = 1'b1;
          state_d    = RD;
          ram_cs_d   = 1'b1;
          ram_addr_d = rd_ptr_q;
        end else if (f.wr_en && !full_w) begin
          wr_ack_w   = 1'b1;
          wr_buf_d   = f.wr_data;
          state_d    = WR;
          ram_cs_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = wr_ptr_q;
        end
      end
      WR: begin
        // Pointer width equals log2(DEPTH), so the increment wraps by itself.
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
        state_d  = IDLE;
      end
      RD: begin
        // The RAM drives the bus during the whole RD cycle; sample at its end.
        rd_data_d  = ram_data;
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        count_d    = count_q - 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_buf_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_buf_q   <= wr_buf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  // ram_we_q is high exactly in WR, so the bus is released whenever the RAM
  // may be driving it and reset releases it immediately.
  assign ram_data = ram_we_q ? wr_buf_q : {DATA_WIDTH{1'bz}};

  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign dbg_state = state_q;

  assign f.ready    = (state_q == IDLE);
  assign f.wr_ack   = wr_ack_w;
  assign f.rd_ack   = rd_ack_w;
  assign f.rd_data  = rd_data_q;
  assign f.rd_valid = rd_valid_q;
  assign f.full     = full_w;
  assign f.empty    = empty_w;
  assign f.count    = count_q;

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives the asynchronous 16x8 RAM bus (chip select, write enable, address, bidirectional data) and uses the RAM as FIFO storage. It sits directly upstream of the RAM. It converts clocked push/pop requests into single-cycle RAM bus operations. It tracks the read and write pointers, the fill count and the full/empty flags.

Parameters:
DATA_WIDTH, 8, width of the FIFO word and the RAM data bus
ADDR_WIDTH, 4, width of the RAM address and of each pointer
DEPTH, 16, number of RAM words used; must equal 2**ADDR_WIDTH

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-low
wr_en  input  1  push request; sampled only while ready=1
wr_data  input  DATA_WIDTH  push word; captured on the accepting edge
rd_en  input  1  pop request; sampled only while ready=1
ready  output  1  controller idle; requests are accepted this cycle
wr_ack  output  1  combinational; push accepted this cycle
rd_ack  output  1  combinational; pop accepted this cycle
rd_data  output  DATA_WIDTH  popped word, registered
rd_valid  output  1  one-cycle pulse; rd_data is new
full  output  1  count==DEPTH
empty  output  1  count==0
count  output  ADDR_WIDTH+1  current fill level, 0..DEPTH
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address, registered
ram_data  inout  DATA_WIDTH  RAM data bus; driven only in WR state, else high-Z

Behaviour:
- Reset (rst=0, asynchronous, effective mid-operation):
  - state=IDLE.
  - ram_cs=0, ram_we=0, ram_addr=0, ram_data=Z.
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
  - rd_data=0, rd_valid=0.
  - An interrupted operation is dropped. RAM contents are not touched.
- FSM states: IDLE, WR, RD. ready=1 only in IDLE.
- IDLE:
  - If rd_en=1 and empty=0: rd_ack=1; next state=RD; ram_addr<=rd_ptr.
  - Else if wr_en=1 and full=0: wr_ack=1; latch wr_data; next state=WR; ram_addr<=wr_ptr.
  - Else stay in IDLE. ram_cs=0, ram_we=0.
- Simultaneous wr_en and rd_en in IDLE: the pop wins and the push is not acked; the requester holds wr_en. If empty=1, the push is accepted instead.
- Push while full=1 and pop while empty=1 are ignored: no ack, no state change.
- WR (exactly one cycle):
  - ram_cs=1, ram_we=1, ram_data=latched word.
  - On exit: wr_ptr+1, count+1, state=IDLE.
- RD (exactly one cycle):
  - ram_cs=1, ram_we=0, ram_data=Z.
  - On exit: rd_data<=ram_data, rd_valid<=1 for one cycle, rd_ptr+1, count-1, state=IDLE.
- Bus outputs (ram_cs, ram_we, ram_addr) are registered and change only at clock edges. ram_addr is stable for the whole cs-active cycle.
- Pointers wrap modulo DEPTH (15 -> 0). count never leaves 0..DEPTH. full and empty are decoded from the registered count.
- Throughput: one operation per 2 cycles.
- Push latency: the word is in RAM at the end of the cycle after the ack.
- Pop latency: rd_valid rises 2 edges after the cycle in which rd_ack=1.
- The controller never drives ram_data while ram_we=0, so there is no bus contention with RAM read drive.

Test Plan:
1. Release rst, idle 3 cycles -> empty=1, full=0, count=0, ram_cs=0, ram_data=Z, ready=1.
2. Push 0xA5, then pop -> WR cycle shows cs=1, we=1, addr=0, data=0xA5. RD cycle shows cs=1, we=0, addr=0. Then rd_data=0xA5, rd_valid pulses once, count returns to 0, empty=1.
3. Push 0x00..0x0F (16 words) -> full=1 and count=16 after the 16th write. A 17th push gets wr_ack=0 and no WR cycle. Then pop 16 words -> data 0x00..0x0F in order, then empty=1.
4. Wrap-around: push 12, pop 12, push 8 (0x30..0x37), pop 8 -> writes use addr 12..15 then 0..3, and data returns 0x30..0x37 in order.
5. With count=3, assert wr_en and rd_en together -> rd_ack=1, wr_ack=0, count becomes 2. On the next ready cycle the push is acked and count returns to 3. With count=0 and both asserted -> push acked.
6. Assert rst=0 asynchronously mid-WR cycle -> ram_cs, ram_we and count drop to 0 immediately, ram_data=Z, and the FSM restarts in IDLE after release.
